// File: rtl/rotary_pkg.sv
// rotary_pkg: shared definitions for the front-panel rotary decoder.
//   - dec_state_t : 3-bit encoding of the quadrature decode FSM
//   - PINS_IDLE   : {ck,dt} level of an encoder resting on a detent
//   - PIN_IDLE_LEVEL : reset/idle level of each encoder pin
//   - STEP_CW / STEP_CCW : signed step issued per completed detent
package rotary_pkg;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_CW1  = 3'd1,
    ST_CW2  = 3'd2,
    ST_CW3  = 3'd3,
    ST_CCW1 = 3'd4,
    ST_CCW2 = 3'd5,
    ST_CCW3 = 3'd6
  } dec_state_t;

  localparam logic [1:0] PINS_IDLE      = 2'b11;
  localparam logic       PIN_IDLE_LEVEL = 1'b1;

  localparam int STEP_CW  = 1;
  localparam int STEP_CCW = -1;

endpackage

// File: rtl/debounce_filter.sv
// debounce_filter: two-flop synchronizer followed by a stability filter for
// one asynchronous encoder pin. A new level is accepted only after the
// synchronized input has differed from the accepted level for CYCLES
// consecutive clocks.
// Ports:
//   aclk    in  system clock
//   aresetn in  asynchronous active-low reset
//   d       in  raw asynchronous pin
//   q       out debounced level (resets to the idle level)
module debounce_filter
  import rotary_pkg::*;
#(
  parameter int CYCLES = 1000
) (
  input  logic aclk,
  input  logic aresetn,
  input  logic d,
  output logic q
);

  localparam int              CNT_W    = $clog2(CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CYCLES - 1);

  logic             sync1;
  logic             sync2;
  logic [CNT_W-1:0] cnt;

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      sync1 <= PIN_IDLE_LEVEL;
      sync2 <= PIN_IDLE_LEVEL;
      q     <= PIN_IDLE_LEVEL;
      cnt   <= '0;
    end else begin
      sync1 <= d;
      sync2 <= sync1;
      if (sync2 == q) begin
        cnt <= '0;
      end else if (cnt == CNT_LAST) begin
        // This clock is the CYCLES-th consecutive mismatch.
        q   <= sync2;
        cnt <= '0;
      end else begin
        cnt <= cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/rotary_decoder.sv
// rotary_decoder: quadrature decoder for the front-panel frequency encoder.
// Debounces the ck/dt pins, decodes full detent cycles into signed steps,
// accumulates them with saturation and hands the count to the controller
// through a read_enable/out_valid capture-and-clear handshake.
// Ports:
//   aclk        in  system clock
//   aresetn     in  asynchronous active-low reset
//   ck, dt      in  encoder channels A/B (asynchronous, idle high)
//   read_enable in  level read request, held until out_valid is seen
//   out         out signed step count captured at the last read
//   out_valid   out out holds a fresh capture for this read_enable assertion
//
// Decode FSM (stable {ck,dt}):
//   state | meaning
//   IDLE  | resting on a detent (11)
//   CW1   | CW started, saw 01
//   CW2   | CW half way, saw 00
//   CW3   | CW nearly done, saw 10; 11 next issues +1
//   CCW1  | CCW started, saw 10
//   CCW2  | CCW half way, saw 00
//   CCW3  | CCW nearly done, saw 01; 11 next issues -1
module rotary_decoder
  import rotary_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 1000,
  parameter int COUNT_WIDTH     = 8
) (
  input  logic                          aclk,
  input  logic                          aresetn,
  input  logic                          ck,
  input  logic                          dt,
  input  logic                          read_enable,
  output logic signed [COUNT_WIDTH-1:0] out,
  output logic                          out_valid
);

  localparam logic signed [COUNT_WIDTH-1:0] ACC_MAX = {1'b0, {(COUNT_WIDTH-1){1'b1}}};
  localparam logic signed [COUNT_WIDTH-1:0] ACC_MIN = {1'b1, {(COUNT_WIDTH-1){1'b0}}};
  localparam logic signed [COUNT_WIDTH-1:0] UP_VAL  = COUNT_WIDTH'(STEP_CW);
  localparam logic signed [COUNT_WIDTH-1:0] DN_VAL  = COUNT_WIDTH'(STEP_CCW);

  logic       ck_s;
  logic       dt_s;
  logic [1:0] pins;

  debounce_filter #(.CYCLES(DEBOUNCE_CYCLES)) u_db_ck (
    .aclk    (aclk),
    .aresetn (aresetn),
    .d       (ck),
    .q       (ck_s)
  );

  debounce_filter #(.CYCLES(DEBOUNCE_CYCLES)) u_db_dt (
    .aclk    (aclk),
    .aresetn (aresetn),
    .d       (dt),
    .q       (dt_s)
  );

  assign pins = {ck_s, dt_s};

  dec_state_t state;
  dec_state_t state_nxt;
  logic       step_up;
  logic       step_dn;

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) state <= ST_IDLE;
    else          state <= state_nxt;
  end

  // Each state lists its forward and backward neighbours plus "hold";
  // everything else (11 mid-detent, illegal jumps) falls back to IDLE.
  always_comb begin
    state_nxt = state;
    step_up   = 1'b0;
    step_dn   = 1'b0;
    case (state)
      ST_IDLE: begin
        case (pins)
          2'b01:   state_nxt = ST_CW1;
          2'b10:   state_nxt = ST_CCW1;
          default: state_nxt = ST_IDLE;
        endcase
      end
      ST_CW1: begin
        case (pins)
          2'b00:   state_nxt = ST_CW2;
          2'b01:   state_nxt = ST_CW1;
          default: state_nxt = ST_IDLE;
        endcase
      end
      ST_CW2: begin
        case (pins)
          2'b10:   state_nxt = ST_CW3;
          2'b01:   state_nxt = ST_CW1;
          2'b00:   state_nxt = ST_CW2;
          default: state_nxt = ST_IDLE;
        endcase
      end
      ST_CW3: begin
        case (pins)
          PINS_IDLE: begin
            state_nxt = ST_IDLE;
            step_up   = 1'b1;
          end
          2'b00:   state_nxt = ST_CW2;
          2'b10:   state_nxt = ST_CW3;
          default: state_nxt = ST_IDLE;
        endcase
      end
      ST_CCW1: begin
        case (pins)
          2'b00:   state_nxt = ST_CCW2;
          2'b10:   state_nxt = ST_CCW1;
          default: state_nxt = ST_IDLE;
        endcase
      end
      ST_CCW2: begin
        case (pins)
          2'b01:   state_nxt = ST_CCW3;
          2'b10:   state_nxt = ST_CCW1;
          2'b00:   state_nxt = ST_CCW2;
          default: state_nxt = ST_IDLE;
        endcase
      end
      ST_CCW3: begin
        case (pins)
          PINS_IDLE: begin
            state_nxt = ST_IDLE;
            step_dn   = 1'b1;
          end
          2'b00:   state_nxt = ST_CCW2;
          2'b01:   state_nxt = ST_CCW3;
          default: state_nxt = ST_IDLE;
        endcase
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  logic signed [COUNT_WIDTH-1:0] acc;
  logic signed [COUNT_WIDTH-1:0] acc_stepped;
  logic signed [COUNT_WIDTH-1:0] step_val;
  logic                          capture;

  // A step that would cross a limit is dropped rather than wrapped.
  always_comb begin
    acc_stepped = acc;
    step_val    = '0;
    if (step_up) begin
      step_val = UP_VAL;
      if (acc != ACC_MAX) acc_stepped = acc + UP_VAL;
    end else if (step_dn) begin
      step_val = DN_VAL;
      if (acc != ACC_MIN) acc_stepped = acc + DN_VAL;
    end
  end

  // out_valid doubles as the "already captured for this assertion" flag:
  // it only drops after read_enable has been seen low.
  assign capture = read_enable && !out_valid;

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      acc       <= '0;
      out       <= '0;
      out_valid <= 1'b0;
    end else if (capture) begin
      // A step landing in the capture cycle seeds the cleared accumulator.
      out       <= acc;
      acc       <= step_val;
      out_valid <= 1'b1;
    end else begin
      acc <= acc_stepped;
      if (!read_enable) out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_rotary_decoder.sv
module tb_rotary_decoder;

  localparam int DB   = 4;
  localparam int W    = 8;
  localparam int HOLD = 10;

  logic                aclk = 1'b0;
  logic                aresetn;
  logic                ck;
  logic                dt;
  logic                read_enable;
  logic signed [W-1:0] dout;
  logic                out_valid;

  int tests_run = 0;
  int tests_failed = 0;
  int model_acc = 0;
  int exp_q[$];

  rotary_decoder #(.DEBOUNCE_CYCLES(DB), .COUNT_WIDTH(W)) dut (
    .aclk        (aclk),
    .aresetn     (aresetn),
    .ck          (ck),
    .dt          (dt),
    .read_enable (read_enable),
    .out         (dout),
    .out_valid   (out_valid)
  );

  always #5 aclk = ~aclk;

  task automatic check(input string name, input int act, input int exp);
    tests_run++;
    if (act != exp) begin
      tests_failed++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Reference: a completed detent moves the count by one, clamped to range.
  function automatic int sat(input int v);
    int lim_hi = (1 << (W - 1)) - 1;
    int lim_lo = -(1 << (W - 1));
    if (v > lim_hi) return lim_hi;
    if (v < lim_lo) return lim_lo;
    return v;
  endfunction

  // Monitor: every fresh out_valid is matched against the oldest expected read.
  task automatic monitor();
    logic prev = 1'b0;
    int   e;
    forever begin
      @(negedge aclk);
      if (out_valid && !prev) begin
        if (exp_q.size() == 0) begin
          check("unexpected_capture", 1, 0);
        end else begin
          e = exp_q.pop_front();
          check("read_value", int'($signed(dout)), e);
        end
      end
      prev = out_valid;
    end
  endtask

  // Called at a negedge; optional glitch to the new level first.
  task automatic move(input logic [1:0] lv, input int glitch);
    logic [1:0] prev;
    int g;
    prev = {ck, dt};
    g = (glitch < 0) ? $urandom_range(0, 3) : glitch;
    if (g > 0) begin
      {ck, dt} = lv;
      repeat (g) @(negedge aclk);
      {ck, dt} = prev;
      repeat (3) @(negedge aclk);
    end
    {ck, dt} = lv;
    repeat (HOLD) @(negedge aclk);
  endtask

  task automatic detent(input int dir, input int glitch);
    if (dir > 0) begin
      move(2'b01, glitch); move(2'b00, glitch); move(2'b10, glitch); move(2'b11, glitch);
    end else begin
      move(2'b10, glitch); move(2'b00, glitch); move(2'b01, glitch); move(2'b11, glitch);
    end
    model_acc = sat(model_acc + dir);
  endtask

  task automatic start_read(input int exp);
    @(negedge aclk);
    exp_q.push_back(exp);
    read_enable = 1'b1;
    @(posedge aclk); #1;
    check("valid_latency", int'(out_valid), 1);
  endtask

  task automatic finish_read(input int exp);
    repeat (2) @(posedge aclk);
    #1 check("valid_held", int'(out_valid), 1);
    @(negedge aclk);
    read_enable = 1'b0;
    @(posedge aclk); #1;
    check("valid_clear", int'(out_valid), 0);
    check("out_hold", int'($signed(dout)), exp);
    @(negedge aclk);
  endtask

  task automatic do_read();
    int e;
    e = model_acc;
    model_acc = 0;
    start_read(e);
    finish_read(e);
  endtask

  initial begin
    int e;
    aresetn = 1'b0;
    ck = 1'b1;
    dt = 1'b1;
    read_enable = 1'b0;
    fork
      monitor();
    join_none
    repeat (3) @(negedge aclk);
    check("reset_out", int'($signed(dout)), 0);
    check("reset_valid", int'(out_valid), 0);
    aresetn = 1'b1;
    repeat (3) @(negedge aclk);

    // Three clean CW detents, then a second empty read.
    repeat (3) detent(1, 0);
    do_read();
    do_read();

    // Bounce rejection on a CCW detent.
    detent(-1, 3);
    do_read();

    // Saturation both ways.
    repeat (130) detent(1, 0);
    do_read();
    repeat (200) detent(-1, 0);
    do_read();

    // Reversal mid-detent and an illegal jump: no steps.
    move(2'b01, 0); move(2'b00, 0); move(2'b01, 0); move(2'b11, 0);
    move(2'b00, 0); move(2'b11, 0);
    do_read();

    // Step landing in the capture cycle.
    repeat (5) detent(1, 0);
    move(2'b01, 0); move(2'b00, 0); move(2'b10, 0);
    {ck, dt} = 2'b11;
    repeat (2 + DB) @(posedge aclk);
    e = model_acc;
    model_acc = sat(0 + 1);
    start_read(e);
    finish_read(e);
    repeat (HOLD) @(negedge aclk);
    do_read();

    // Randomized mix.
    for (int i = 0; i < 30; i++) begin
      case ($urandom_range(0, 4))
        0: detent(1, -1);
        1: detent(-1, -1);
        2: begin
          if ($urandom_range(0, 1) == 1) begin
            move(2'b01, -1); move(2'b00, -1); move(2'b01, -1); move(2'b11, -1);
          end else begin
            move(2'b10, -1); move(2'b00, -1); move(2'b10, -1); move(2'b11, -1);
          end
        end
        3: begin move(2'b00, -1); move(2'b11, -1); end
        default: do_read();
      endcase
    end
    do_read();

    // Async reset mid-sequence while a capture is held.
    repeat (7) detent(1, 0);
    e = model_acc;
    model_acc = 0;
    start_read(e);
    repeat (7) detent(1, 0);
    check("single_capture_out", int'($signed(dout)), 7);
    check("single_capture_valid", int'(out_valid), 1);
    move(2'b01, 0);
    move(2'b00, 0);
    #2 aresetn = 1'b0;
    #1;
    check("async_reset_out", int'($signed(dout)), 0);
    check("async_reset_valid", int'(out_valid), 0);
    model_acc = 0;
    read_enable = 1'b0;
    repeat (3) @(negedge aclk);
    aresetn = 1'b1;
    repeat (HOLD) @(negedge aclk);
    move(2'b11, 0);
    do_read();

    repeat (5) @(negedge aclk);
    check("scoreboard_drained", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
